// File: rtl/wb_seq_pkg.sv
// wb_seq_pkg: opcodes, FSM states and decode helpers shared by the sequencer
package wb_seq_pkg;
   localparam logic [3:0] OP_WAIT      = 4'd0;
   localparam logic [3:0] OP_READ      = 4'd1;
   localparam logic [3:0] OP_WRITE_IMD = 4'd2;
   localparam logic [3:0] OP_WRITE_REG = 4'd3;
   localparam logic [3:0] OP_POLL      = 4'd4;
   localparam logic [3:0] OP_JUMP      = 4'd5;
   localparam logic [3:0] OP_HALT      = 4'd6;
   typedef enum logic [1:0] {S_DEC, S_WAIT, S_BUS, S_HALT} state_e;
   function automatic logic is_bus(input logic [3:0] op);
      return op inside {OP_READ, OP_WRITE_IMD, OP_WRITE_REG, OP_POLL};
   endfunction
   function automatic logic is_write(input logic [3:0] op);
      return op == OP_WRITE_IMD || op == OP_WRITE_REG;
   endfunction
endpackage

// File: rtl/wb_seq_rom.sv
// wb_seq_rom: program memory with an async read port and a load port
module wb_seq_rom #(
   parameter int PCW = 8,
   parameter int IW  = 48
) (
   input  logic           i_clk,
   input  logic           i_we,
   input  logic [PCW-1:0] i_wadr,
   input  logic [IW-1:0]  i_wdat,
   input  logic [PCW-1:0] i_radr,
   output logic [IW-1:0]  o_rdat
);
   logic [IW-1:0] r_mem [2**PCW];
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_wadr] <= i_wdat;
   end
   assign o_rdat = r_mem[i_radr];
endmodule

// File: rtl/wb_seq_tmo.sv
// wb_seq_tmo: counts bus cycles since strobe and flags a missing ack after TMO cycles
module wb_seq_tmo #(
   parameter int TMO = 1024
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_load,
   input  logic i_en,
   output logic o_expired
);
   localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
   logic [TW-1:0] r_cnt;
   always_ff @(posedge i_clk) begin
      if (i_rst || i_load) r_cnt <= '0;
      else if (i_en && !o_expired) r_cnt <= r_cnt + 1'b1;
   end
   assign o_expired = (TMO > 0) && (r_cnt == TW'(TMO - 1));
endmodule

// File: rtl/wb_seq.sv
// wb_seq: Wishbone master sequencer running a program from an external instruction memory
module wb_seq
   import wb_seq_pkg::*;
#(
   parameter int AW  = 12,
   parameter int DW  = 32,
   parameter int PCW = 8,
   parameter int TMO = 1024
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   output logic [AW-1:0]      wb_adr_o,
   input  logic [DW-1:0]      wb_dat_i,
   output logic [DW-1:0]      wb_dat_o,
   output logic               wb_we_o,
   output logic [DW/8-1:0]    wb_sel_o,
   output logic               wb_stb_o,
   output logic               wb_cyc_o,
   input  logic               wb_ack_i,
   output logic [PCW-1:0]     prog_adr_o,
   input  logic [4+AW+DW-1:0] prog_dat_i,
   input  logic               start_i,
   output logic [DW-1:0]      rdata_o,
   output logic               halted_o,
   output logic               err_o
);
   logic [3:0]     w_iop;
   logic [AW-1:0]  w_iadr;
   logic [DW-1:0]  w_iimm;
   state_e         r_state, w_state_n;
   logic [PCW-1:0] r_pc, w_pc_n;
   logic [DW-1:0]  r_cnt, w_cnt_n, r_imm, w_imm_n, r_dat, w_dat_n, r_rdata, w_rdata_n;
   logic [3:0]     r_op, w_op_n;
   logic [AW-1:0]  r_adr, w_adr_n;
   logic           r_we, w_we_n, r_cyc, w_cyc_n, r_err, w_err_n;
   logic           w_tmo_load, w_tmo_en, w_tmo_exp, w_rd;
   assign {w_iop, w_iadr, w_iimm} = prog_dat_i;
   assign w_rd = (r_op == OP_READ) || (r_op == OP_POLL);
   wb_seq_tmo #(.TMO(TMO)) u_tmo (
      .i_clk(wb_clk_i), .i_rst(wb_rst_i), .i_load(w_tmo_load), .i_en(w_tmo_en), .o_expired(w_tmo_exp)
   );
   always_comb begin
      w_state_n  = r_state;
      w_pc_n     = r_pc;
      w_cnt_n    = r_cnt;
      w_op_n     = r_op;
      w_imm_n    = r_imm;
      w_adr_n    = r_adr;
      w_dat_n    = r_dat;
      w_we_n     = r_we;
      w_cyc_n    = r_cyc;
      w_rdata_n  = r_rdata;
      w_err_n    = r_err;
      w_tmo_load = 1'b0;
      w_tmo_en   = 1'b0;
      case (r_state)
         S_DEC: begin
            w_op_n     = w_iop;
            w_adr_n    = w_iadr;
            w_imm_n    = w_iimm;
            w_cnt_n    = w_iimm;
            w_dat_n    = (w_iop == OP_WRITE_REG) ? r_rdata : w_iimm;
            w_we_n     = is_write(w_iop);
            w_cyc_n    = is_bus(w_iop);
            w_tmo_load = 1'b1;
            w_state_n  = (w_iop == OP_WAIT) ? S_WAIT : is_bus(w_iop) ? S_BUS :
                         (w_iop == OP_HALT) ? S_HALT : S_DEC;
            w_pc_n     = (w_iop == OP_JUMP) ? w_iimm[PCW-1:0] :
                         (w_state_n == S_DEC) ? r_pc + 1'b1 : r_pc;
         end
         S_WAIT: begin
            // an all-ones count never decrements, so the wait never ends
            w_cnt_n   = (r_cnt == '1 || r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
            w_state_n = (r_cnt == '0) ? S_DEC : S_WAIT;
            w_pc_n    = (r_cnt == '0) ? r_pc + 1'b1 : r_pc;
         end
         S_BUS: begin
            w_tmo_en = 1'b1;
            if (wb_ack_i) begin
               w_state_n = S_DEC;
               w_cyc_n   = 1'b0;
               w_we_n    = 1'b0;
               w_rdata_n = w_rd ? wb_dat_i : r_rdata;
               w_pc_n    = (r_op == OP_POLL && (wb_dat_i & r_imm) == '0) ? r_pc : r_pc + 1'b1;
            end else if (w_tmo_exp) begin
               w_state_n = S_HALT;
               w_cyc_n   = 1'b0;
               w_we_n    = 1'b0;
               w_err_n   = 1'b1;
            end
         end
         S_HALT: begin
            w_state_n = start_i ? S_DEC : S_HALT;
            w_pc_n    = start_i ? '0 : r_pc;
            w_err_n   = start_i ? 1'b0 : r_err;
         end
         default: w_state_n = S_DEC;
      endcase
   end
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= S_DEC;
         r_pc    <= '0;
         r_cnt   <= '0;
         r_op    <= '0;
         r_imm   <= '0;
         r_adr   <= '0;
         r_dat   <= '0;
         r_we    <= 1'b0;
         r_cyc   <= 1'b0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_pc    <= w_pc_n;
         r_cnt   <= w_cnt_n;
         r_op    <= w_op_n;
         r_imm   <= w_imm_n;
         r_adr   <= w_adr_n;
         r_dat   <= w_dat_n;
         r_we    <= w_we_n;
         r_cyc   <= w_cyc_n;
         r_rdata <= w_rdata_n;
         r_err   <= w_err_n;
      end
   end
   assign wb_adr_o   = r_adr;
   assign wb_dat_o   = r_dat;
   assign wb_we_o    = r_we;
   assign wb_sel_o   = '1;
   assign wb_stb_o   = r_cyc;
   assign wb_cyc_o   = r_cyc;
   assign prog_adr_o = r_pc;
   assign rdata_o    = r_rdata;
   assign halted_o   = (r_state == S_HALT);
   assign err_o      = r_err;
endmodule
